cpu_sequencer: RTL and testbench

Multi-cycle run controller for the 8-bit single-cycle core. It fetches each instruction from an external instruction memory over a req/valid handshake and latches it. It then issues a one-cycle execute enable so the core commits exactly one instruction per enable pulse. It also handles run, single-step, halt and PC breakpoints, and sits between the instruction ROM and the core, replacing free-running instruction issue.

---
 rtl/cpu_sequencer_pkg.sv | 15 +
 rtl/seq_bp_unit.sv | 30 +++
 rtl/cpu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the cpu_sequencer run controller: FSM state encoding
// and the default address / instruction widths.
package cpu_sequencer_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } seq_state_t;

endpackage

// File: rtl/seq_bp_unit.sv
// PC breakpoint comparator with a one-shot suppress flag, so that resuming
// from a breakpoint can fetch the instruction sitting at the breakpoint PC.
module seq_bp_unit #(
   parameter int ADDR_W = cpu_sequencer_pkg::ADDR_W
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic [ADDR_W-1:0] pc,
   input  logic              arm,
   input  logic              consume,
   output logic              bp_stop
);

   logic suppress;

   always_ff @(posedge clock) begin
      if (clear) begin
         suppress <= 1'b0;
      end else if (arm) begin
         suppress <= 1'b1;
      end else if (consume) begin
         suppress <= 1'b0;
      end
   end

   assign bp_stop = bp_en && (pc == bp_addr) && !suppress;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute run controller for the 8-bit core: run, single-step, halt and
// PC breakpoint. Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module cpu_sequencer #(
   parameter int ADDR_W         = cpu_sequencer_pkg::ADDR_W,
   parameter int INSTR_W        = cpu_sequencer_pkg::INSTR_W,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               run,
   input  logic               step,
   input  logic               halt_req,
   input  logic               bp_en,
   input  logic [ADDR_W-1:0]  bp_addr,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic               fetch_req,
   output logic [ADDR_W-1:0]  fetch_addr,
   input  logic               fetch_valid,
   input  logic [INSTR_W-1:0] fetch_data,
   output logic [INSTR_W-1:0] instruction,
   output logic               exec_en,
   output logic               halted,
   output logic               bp_hit,
   output logic [CNT_W-1:0]   retired,
`ifdef FETCH_TIMEOUT_EN
   output logic               fetch_err,
`endif
   output logic [1:0]         state
);

   import cpu_sequencer_pkg::*;

   seq_state_t state_q, state_d;
   logic       step_mode;
   logic       halt_pend;
   logic       run_q;
   logic       step_go;
   logic       arm;
   logic       consume;
   logic       bp_stop;
   logic       timeout;

   seq_bp_unit #(.ADDR_W(ADDR_W)) u_bp (
      .clock   (clock),
      .clear   (clear),
      .bp_en   (bp_en),
      .bp_addr (bp_addr),
      .pc      (pc_in),
      .arm     (arm),
      .consume (consume),
      .bp_stop (bp_stop)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   // Counter restarts on every entry into FETCH because it is held at zero elsewhere.
   always_ff @(posedge clock) begin
      if (clear || (state_q != FETCH)) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (clear) begin
         fetch_err <= 1'b0;
      end else if ((state_q == FETCH) && !bp_stop && !fetch_valid && timeout) begin
         fetch_err <= 1'b1;
      end else if ((state_q == HALTED) && (state_d != HALTED)) begin
         fetch_err <= 1'b0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   assign step_go    = step && !halt_req;
   assign fetch_addr = pc_in;
   assign state      = state_q;

   always_comb begin
      state_d   = state_q;
      fetch_req = 1'b0;
      exec_en   = 1'b0;
      halted    = 1'b0;
      arm       = 1'b0;
      consume   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (run || step_go) state_d = FETCH;
         end
         FETCH: begin
            // A breakpoint hit takes priority and never raises the request.
            if (bp_stop) begin
               state_d = HALTED;
            end else begin
               fetch_req = 1'b1;
               if (fetch_valid)  state_d = EXEC;
               else if (timeout) state_d = HALTED;
            end
            consume = (state_d != FETCH);
         end
         EXEC: begin
            exec_en = 1'b1;
            if (step_mode || halt_pend || halt_req) state_d = HALTED;
            else if (run)                           state_d = FETCH;
            else                                    state_d = IDLE;
         end
         HALTED: begin
            halted = 1'b1;
            if (step_go || (run && !run_q && !halt_req)) begin
               state_d = FETCH;
               arm     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q     <= IDLE;
         step_mode   <= 1'b0;
         halt_pend   <= 1'b0;
         run_q       <= 1'b0;
         bp_hit      <= 1'b0;
         instruction <= '0;
         retired     <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run;
         if ((state_d == FETCH) && (state_q != FETCH)) begin
            step_mode <= ((state_q == HALTED) && step_go) || !run;
         end
         // A pending halt is consumed by the EXEC it stops, or by any other halt.
         if ((state_d == HALTED) || (state_q == EXEC)) begin
            halt_pend <= 1'b0;
         end else if (halt_req && (state_q == FETCH)) begin
            halt_pend <= 1'b1;
         end
         if ((state_q == FETCH) && bp_stop) begin
            bp_hit <= 1'b1;
         end else if ((state_q == HALTED) && (state_d != HALTED)) begin
            bp_hit <= 1'b0;
         end
         if ((state_q == FETCH) && (state_d == EXEC)) begin
            instruction <= fetch_data;
         end
         if (exec_en) begin
            retired <= retired + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small core PC model and a
// wait-state instruction memory returning 8'h41 + address.
module tb_cpu_sequencer;

   logic       clock;
   logic       clear;
   logic       run;
   logic       step;
   logic       halt_req;
   logic       bp_en;
   logic [7:0] bp_addr;
   logic [7:0] pc;
   logic       fetch_req;
   logic [7:0] fetch_addr;
   logic       fetch_valid;
   logic [7:0] fetch_data;
   logic [7:0] instruction;
   logic       exec_en;
   logic       halted;
   logic       bp_hit;
   logic [15:0] retired;
   logic [1:0] state;
`ifdef FETCH_TIMEOUT_EN
   logic       fetch_err;
`endif

   logic       pc_load;
   logic [7:0] pc_val;
   logic       mem_on;
   logic       force_valid;
   int         mem_wait;
   int         wcnt;
   int         exec_cnt;
   int         req_cnt;
   int         bp_req_cnt;
   int         n_cmp;
   int         n_bad;
   int         snap;

   cpu_sequencer dut (
      .clock       (clock),
      .clear       (clear),
      .run         (run),
      .step        (step),
      .halt_req    (halt_req),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .pc_in       (pc),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .instruction (instruction),
      .exec_en     (exec_en),
      .halted      (halted),
      .bp_hit      (bp_hit),
      .retired     (retired),
`ifdef FETCH_TIMEOUT_EN
      .fetch_err   (fetch_err),
`endif
      .state       (state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   assign fetch_data  = 8'h41 + fetch_addr;
   assign fetch_valid = force_valid | (mem_on & fetch_req & (wcnt == mem_wait));

   // Core PC advances only on exec_en; memory counts wait cycles per request.
   always @(posedge clock) begin
      if (pc_load)      pc <= pc_val;
      else if (exec_en) pc <= pc + 8'd1;
      if (fetch_req && !fetch_valid) wcnt <= wcnt + 1;
      else                           wcnt <= 0;
      if (exec_en)   exec_cnt <= exec_cnt + 1;
      if (fetch_req) req_cnt  <= req_cnt + 1;
      if (fetch_req && bp_en && (fetch_addr == bp_addr)) bp_req_cnt <= bp_req_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_clear(input logic [7:0] start_pc);
      clear   = 1'b1;
      pc_load = 1'b1;
      pc_val  = start_pc;
      cyc(1);
      clear   = 1'b0;
      pc_load = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      wcnt = 0; exec_cnt = 0; req_cnt = 0; bp_req_cnt = 0;
      run = 0; step = 0; halt_req = 0; bp_en = 0; bp_addr = 8'h00;
      mem_on = 1; force_valid = 0; mem_wait = 0;
      clear = 1; pc_load = 1; pc_val = 8'h00; pc = 8'h00;
      cyc(2);
      clear = 0; pc_load = 0;

      chk("rst_state",   state, 0);
      chk("rst_instr",   instruction, 8'h00);
      chk("rst_exec_en", exec_en, 0);
      chk("rst_req",     fetch_req, 0);
      chk("rst_halted",  halted, 0);
      chk("rst_bp_hit",  bp_hit, 0);
      chk("rst_retired", retired, 0);

      // Zero-wait run: two instructions, run dropped during the second fetch.
      run = 1;
      cyc(1);
      chk("run_fetch_state", state, 1);
      chk("run_fetch_req",   fetch_req, 1);
      chk("run_fetch_addr",  fetch_addr, 8'h00);
      cyc(1);
      chk("run_exec1_en",    exec_en, 1);
      chk("run_exec1_instr", instruction, 8'h41);
      cyc(1);
      chk("run_ret1",        retired, 1);
      chk("run_gap_en",      exec_en, 0);
      chk("run_fetch2",      state, 1);
      run = 0;
      cyc(1);
      chk("run_exec2_en",    exec_en, 1);
      chk("run_exec2_instr", instruction, 8'h42);
      cyc(1);
      chk("run_idle",        state, 0);
      chk("run_ret2",        retired, 2);

      // Single step with a 3-cycle memory at PC 0x05.
      do_clear(8'h05);
      mem_wait = 2;
      snap = exec_cnt;
      step = 1;
      cyc(1);
      step = 0;
      chk("step_req_c1",  fetch_req, 1);
      chk("step_addr_c1", fetch_addr, 8'h05);
      cyc(1);
      chk("step_req_c2",  fetch_req, 1);
      cyc(1);
      chk("step_req_c3",  fetch_req, 1);
      chk("step_addr_c3", fetch_addr, 8'h05);
      cyc(1);
      chk("step_exec_en", exec_en, 1);
      chk("step_instr",   instruction, 8'h46);
      chk("step_req_off", fetch_req, 0);
      cyc(1);
      chk("step_halted",  halted, 1);
      chk("step_retired", retired, 1);
      cyc(2);
      chk("step_one_exec", exec_cnt - snap, 1);
      chk("step_hold_req", fetch_req, 0);

      // Breakpoint at 0x03, step off it, then resume with a run rising edge.
      mem_wait = 0;
      bp_en = 1;
      bp_addr = 8'h03;
      do_clear(8'h00);
      snap = bp_req_cnt;
      run = 1;
      cyc(7);
      chk("bp_fetch_state", state, 1);
      chk("bp_no_req",      fetch_req, 0);
      cyc(1);
      chk("bp_halted",      halted, 1);
      chk("bp_hit_set",     bp_hit, 1);
      chk("bp_retired",     retired, 3);
      chk("bp_pc",          pc, 8'h03);
      chk("bp_req_count",   bp_req_cnt - snap, 0);
      run = 0;
      cyc(1);
      chk("bp_stay_halted", state, 3);
      step = 1;
      cyc(1);
      step = 0;
      chk("bp_step_req",    fetch_req, 1);
      chk("bp_step_addr",   fetch_addr, 8'h03);
      chk("bp_hit_cleared", bp_hit, 0);
      cyc(1);
      chk("bp_step_instr",  instruction, 8'h44);
      cyc(1);
      chk("bp_step_halt",   halted, 1);
      chk("bp_step_pc",     pc, 8'h04);
      chk("bp_step_ret",    retired, 4);
      run = 1;
      cyc(1);
      chk("resume_state",   state, 1);
      chk("resume_addr",    fetch_addr, 8'h04);
      run = 0;
      cyc(2);
      chk("resume_idle",    state, 0);
      chk("resume_ret",     retired, 5);

      // halt_req during a fetch wait: instruction completes, then halt.
      bp_en = 0;
      mem_wait = 2;
      do_clear(8'h08);
      snap = exec_cnt;
      run = 1;
      cyc(1);
      chk("hreq_fetch",   fetch_req, 1);
      cyc(1);
      halt_req = 1;
      cyc(1);
      halt_req = 0;
      chk("hreq_still_fetch", state, 1);
      cyc(1);
      chk("hreq_exec_en", exec_en, 1);
      chk("hreq_instr",   instruction, 8'h49);
      cyc(1);
      chk("hreq_halted",  halted, 1);
      snap = req_cnt;
      cyc(3);
      chk("hreq_no_req",  req_cnt - snap, 0);
      chk("hreq_retired", retired, 1);
      step = 1;
      halt_req = 1;
      cyc(1);
      step = 0;
      halt_req = 0;
      chk("halt_beats_step", state, 3);

      // clear during a fetch, with a late fetch_valid afterwards.
      run = 0;
      cyc(1);
      mem_on = 0;
      run = 1;
      cyc(2);
      chk("clr_in_fetch", fetch_req, 1);
      snap = exec_cnt;
      clear = 1;
      run = 0;
      cyc(1);
      clear = 0;
      chk("clr_state", state, 0);
      chk("clr_instr", instruction, 8'h00);
      force_valid = 1;
      cyc(1);
      force_valid = 0;
      mem_on = 1;
      chk("clr_late_state", state, 0);
      chk("clr_late_instr", instruction, 8'h00);
      cyc(1);
      chk("clr_no_exec", exec_cnt - snap, 0);

`ifdef FETCH_TIMEOUT_EN
      // Fetch watchdog: memory never answers, then a step retries.
      do_clear(8'h10);
      mem_on = 0;
      mem_wait = 0;
      step = 1;
      cyc(1);
      step = 0;
      cyc(14);
      chk("to_req_c15", fetch_req, 1);
      chk("to_err_low", fetch_err, 0);
      cyc(1);
      chk("to_req_drop", fetch_req, 0);
      chk("to_halted",   halted, 1);
      chk("to_err_set",  fetch_err, 1);
      mem_on = 1;
      step = 1;
      cyc(1);
      step = 0;
      chk("to_retry_addr", fetch_addr, 8'h10);
      chk("to_err_clear",  fetch_err, 0);
      cyc(1);
      chk("to_retry_instr", instruction, 8'h51);
      cyc(1);
      chk("to_retry_halt", halted, 1);
      chk("to_retry_ret",  retired, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
